mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_rr_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the memory command encoding, the arbiter FSM state type, the
// address/data widths and a helper that maps reserved commands to MNONE.
package mem_arbiter_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  // Memory command encoding; 2'b11 is reserved and treated as a no-op.
  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Only MREAD and MWRITE reach the memory; anything else becomes MNONE.
  function automatic logic [1:0] legal_cmd(input logic [1:0] cmd);
    if (cmd == MREAD || cmd == MWRITE) begin
      return cmd;
    end
    return MNONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: combinational, zero latency, no backpressure.
// Ports: req[1:0] requests (bit n = port n), last = port granted last time,
//        winner = selected port index, any = at least one request present.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = req[0] | req[1];
    // On a tie the port that did not win last time goes first; otherwise
    // the lone requester wins (req[1] is 1 only when port 1 is the one).
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory.
// Latency: gnt to done is 2 cycles for write/no-op, 2+READ_LAT for read.
// Backpressure: one access in flight; requests wait in IDLE until re-arbitrated.
//
// Ports:
//   clk, reset (async, active low)
//   p0_* / p1_*   : req, cmd, addr, wdata in; gnt and done one-cycle pulses out
//   rdata         : last captured read result, valid with the owner's done
//   mem_cmd/addr/wdata out, mem_rdata in : shared memory interface
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic [1:0]        p0_cmd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,

  input  logic              p1_req,
  input  logic [1:0]        p1_cmd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,

  output logic [DATA_W-1:0] rdata,

  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // WAIT runs for READ_LAT cycles; the counter counts down to zero.
  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_e              state;
  logic                last;     // port granted most recently
  logic                owner;    // port owning the access in flight
  logic [1:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          lat_cnt;

  logic                pick;
  logic                pick_any;

  rr_pick2 u_pick (
    .req    ({p1_req, p0_req}),
    .last   (last),
    .winner (pick),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cmd_q     <= MNONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt   <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      rdata     <= '0;
      mem_cmd   <= MNONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;

      case (state)
        IDLE: begin
          if (p0_gnt || p1_gnt) begin
            // Grant cycle: the request is already latched, so requester
            // inputs are ignored here and the memory registers are loaded
            // so the command is visible for the whole ISSUE cycle.
            state     <= ISSUE;
            mem_cmd   <= legal_cmd(cmd_q);
            mem_addr  <= addr_q;
            mem_wdata <= wdata_q;
          end else if (pick_any) begin
            owner   <= pick;
            last    <= pick;
            p0_gnt  <= ~pick;
            p1_gnt  <= pick;
            cmd_q   <= pick ? p1_cmd   : p0_cmd;
            addr_q  <= pick ? p1_addr  : p0_addr;
            wdata_q <= pick ? p1_wdata : p0_wdata;
          end
        end

        ISSUE: begin
          if (cmd_q == MREAD) begin
            // Keep MREAD and the address on the bus through WAIT.
            state   <= WAIT;
            lat_cnt <= LAT_INIT;
          end else begin
            // Writes and no-ops finish straight away.
            state   <= DONE;
            mem_cmd <= MNONE;
            p0_done <= ~owner;
            p1_done <= owner;
          end
        end

        WAIT: begin
          if (lat_cnt == 2'd0) begin
            rdata   <= mem_rdata;
            mem_cmd <= MNONE;
            state   <= DONE;
            p0_done <= ~owner;
            p1_done <= owner;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_cmd <= MNONE;
        end
      endcase
    end
  end

endmodule
